// File: rtl/ac_terminate_ser_if.sv
// Handshake and payload bundle between a termination requester and ac_terminate_ser.
interface ac_terminate_ser_if #(
    parameter int unsigned N  = 9,
    parameter int unsigned CW = 7
);
    logic          start;
    logic [N-1:0]  low_in;
    logic [CW-1:0] e3_in;
    logic          bit_out;
    logic          bit_valid;
    logic          bit_ready;
    logic          busy;
    logic          done;
    logic [CW+4:0] bits_sent;

    modport master (
        output start, low_in, e3_in, bit_ready,
        input  bit_out, bit_valid, busy, done, bits_sent
    );

    modport slave (
        input  start, low_in, e3_in, bit_ready,
        output bit_out, bit_valid, busy, done, bits_sent
    );
endinterface

// File: rtl/ac_terminate_ser.sv
// Arithmetic-coder termination serializer: emits the low-register MSB, the pending
// E3 bits (inverted MSB) and the remaining flush bits over a valid/ready bit stream.
module ac_terminate_ser #(
    parameter int unsigned N          = 9,
    parameter int unsigned CW         = 7,
    parameter int unsigned FLUSH_BITS = N
) (
    input  logic               sys_clk,
    input  logic               sys_reset,
    ac_terminate_ser_if.slave  bus
);
    localparam int unsigned IW        = $clog2(N);
    localparam int unsigned BW        = CW + 5;
    localparam int unsigned REM_FIRST = N - 2;
    localparam int unsigned REM_LAST  = N - FLUSH_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MSB,
        S_E3,
        S_REM,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    low_q, low_d;
    logic [CW-1:0]   e3_q, e3_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [BW-1:0]   sent_q, sent_d;
    logic            bit_out_q, bit_out_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            xfer_c;
    logic            tail_c;

    assign xfer_c        = valid_q & bus.bit_ready;
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bits_sent = sent_q;

    // State and datapath registers
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q   <= S_IDLE;
            low_q     <= '0;
            e3_q      <= '0;
            idx_q     <= '0;
            sent_q    <= '0;
            bit_out_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            low_q     <= low_d;
            e3_q      <= e3_d;
            idx_q     <= idx_d;
            sent_q    <= sent_d;
            bit_out_q <= bit_out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a transfer advances it
    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        e3_d      = e3_q;
        idx_d     = idx_q;
        sent_d    = sent_q;
        bit_out_d = bit_out_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tail_c    = 1'b0;

        if (xfer_c) begin
            sent_d = sent_q + BW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_MSB;
                    low_d     = bus.low_in;
                    e3_d      = bus.e3_in;
                    sent_d    = '0;
                    bit_out_d = bus.low_in[N-1];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_MSB: begin
                if (xfer_c) begin
                    if (e3_q != '0) begin
                        state_d   = S_E3;
                        bit_out_d = ~low_q[N-1];
                    end else begin
                        tail_c = 1'b1;
                    end
                end
            end
            S_E3: begin
                if (xfer_c) begin
                    e3_d = e3_q - CW'(1);
                    if (e3_q == CW'(1)) begin
                        tail_c = 1'b1;
                    end
                end
            end
            S_REM: begin
                if (xfer_c) begin
                    if (idx_q == IW'(REM_LAST)) begin
                        state_d   = S_DONE;
                        bit_out_d = 1'b0;
                        valid_d   = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        idx_d     = idx_q - IW'(1);
                        bit_out_d = low_q[idx_q - IW'(1)];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Leaving MSB/E3: either flush the remaining low bits or finish
        if (tail_c) begin
            if (FLUSH_BITS > 1) begin
                state_d   = S_REM;
                idx_d     = IW'(REM_FIRST);
                bit_out_d = low_q[IW'(REM_FIRST)];
            end else begin
                state_d   = S_DONE;
                bit_out_d = 1'b0;
                valid_d   = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ac_terminate_ser.sv
// Self-checking bench for ac_terminate_ser: three flush-length instances, directed and random terminations.
module tb_ac_terminate_ser;
    localparam int unsigned N  = 9;
    localparam int unsigned CW = 7;

    logic          sys_clk;
    logic          sys_reset;
    int            sel;
    logic          start_v;
    logic [N-1:0]  low_v;
    logic [CW-1:0] e3_v;
    logic          ready_v;

    int n_cmp;
    int n_err;
    bit exp_q[$];

    logic          mon_bit, mon_valid, mon_busy, mon_done;
    logic [CW+4:0] mon_sent;

    ac_terminate_ser_if #(.N(N), .CW(CW)) bus0 ();
    ac_terminate_ser_if #(.N(N), .CW(CW)) bus1 ();
    ac_terminate_ser_if #(.N(N), .CW(CW)) bus2 ();

    assign bus0.start     = start_v && (sel == 0);
    assign bus1.start     = start_v && (sel == 1);
    assign bus2.start     = start_v && (sel == 2);
    assign bus0.low_in    = low_v;
    assign bus1.low_in    = low_v;
    assign bus2.low_in    = low_v;
    assign bus0.e3_in     = e3_v;
    assign bus1.e3_in     = e3_v;
    assign bus2.e3_in     = e3_v;
    assign bus0.bit_ready = ready_v;
    assign bus1.bit_ready = ready_v;
    assign bus2.bit_ready = ready_v;

    ac_terminate_ser #(.N(N), .CW(CW), .FLUSH_BITS(9)) u_dut0 (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .bus(bus0));
    ac_terminate_ser #(.N(N), .CW(CW), .FLUSH_BITS(2)) u_dut1 (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .bus(bus1));
    ac_terminate_ser #(.N(N), .CW(CW), .FLUSH_BITS(1)) u_dut2 (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .bus(bus2));

    always_comb begin
        case (sel)
            1: begin
                mon_bit = bus1.bit_out; mon_valid = bus1.bit_valid; mon_busy = bus1.busy;
                mon_done = bus1.done; mon_sent = bus1.bits_sent;
            end
            2: begin
                mon_bit = bus2.bit_out; mon_valid = bus2.bit_valid; mon_busy = bus2.busy;
                mon_done = bus2.done; mon_sent = bus2.bits_sent;
            end
            default: begin
                mon_bit = bus0.bit_out; mon_valid = bus0.bit_valid; mon_busy = bus0.busy;
                mon_done = bus0.done; mon_sent = bus0.bits_sent;
            end
        endcase
    end

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    function automatic int flush_of(input int s);
        case (s)
            1:       return 2;
            2:       return 1;
            default: return 9;
        endcase
    endfunction

    // Reference: MSB, then e3 inverted MSBs, then the next flush-1 bits of low
    function automatic void build_expected(input logic [N-1:0] low, input int e3, input int f);
        exp_q.delete();
        exp_q.push_back(low[N-1]);
        for (int i = 0; i < e3; i++) exp_q.push_back(~low[N-1]);
        for (int i = N - 2; i >= int'(N) - f; i--) exp_q.push_back(low[i]);
    endfunction

    task automatic run_term(input int s, input logic [N-1:0] low, input int e3,
                            input int mode, input bit restart, input int abort_at);
        int   got;
        int   budget;
        bit   fin;
        bit   aborted;
        bit   prev_stall;
        logic prev_bit;
        got = 0; fin = 0; aborted = 0; prev_stall = 0; prev_bit = 1'b0;
        build_expected(low, e3, flush_of(s));
        budget = 10 * exp_q.size() + 20;
        sel = s;
        @(negedge sys_clk);
        start_v = 1'b1; low_v = low; e3_v = CW'(e3); ready_v = 1'($urandom);
        @(negedge sys_clk);
        start_v = 1'b0; low_v = N'($urandom); e3_v = CW'($urandom);
        chk("first_valid", 32'(mon_valid), 1);
        chk("busy_rise", 32'(mon_busy), 1);
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            if (cyc > 0) @(negedge sys_clk);
            if (got == exp_q.size()) begin
                chk("done_pulse", 32'(mon_done), 1);
                chk("done_valid", 32'(mon_valid), 0);
                chk("done_busy", 32'(mon_busy), 0);
                chk("bits_sent_final", 32'(mon_sent), 32'(exp_q.size()));
                fin = 1;
            end else begin
                chk("valid_held", 32'(mon_valid), 1);
                chk("busy_high", 32'(mon_busy), 1);
                chk("no_early_done", 32'(mon_done), 0);
                chk("bits_sent_run", 32'(mon_sent), 32'(got));
                if (prev_stall) chk("stall_stable", 32'(mon_bit), 32'(prev_bit));
                if (restart && cyc == 1) begin
                    start_v = 1'b1; low_v = ~low; e3_v = CW'(e3 + 5);
                end else begin
                    start_v = 1'b0;
                end
                case (mode)
                    1:       ready_v = (cyc % 3 == 0);
                    2:       ready_v = ($urandom_range(0, 3) != 0);
                    default: ready_v = 1'b1;
                endcase
                if (mon_valid && ready_v) begin
                    chk("bit_value", 32'(mon_bit), 32'(exp_q[got]));
                    got++;
                    prev_stall = 0;
                    if (abort_at != 0 && got == abort_at) begin
                        @(negedge sys_clk);
                        sys_reset = 1'b0;
                        #1;
                        chk("rst_bit_out", 32'(mon_bit), 0);
                        chk("rst_valid", 32'(mon_valid), 0);
                        chk("rst_busy", 32'(mon_busy), 0);
                        chk("rst_done", 32'(mon_done), 0);
                        chk("rst_bits_sent", 32'(mon_sent), 0);
                        @(negedge sys_clk);
                        chk("rst_no_done", 32'(mon_done), 0);
                        sys_reset = 1'b1;
                        aborted = 1;
                        fin = 1;
                    end
                end else begin
                    prev_stall = mon_valid;
                    prev_bit   = mon_bit;
                end
            end
        end
        start_v = 1'b0;
        if (!fin) begin
            chk("timeout", 0, 1);
        end else if (!aborted) begin
            ready_v = 1'b1;
            @(negedge sys_clk);
            chk("done_one_cycle", 32'(mon_done), 0);
            chk("idle_valid", 32'(mon_valid), 0);
            chk("bits_sent_hold", 32'(mon_sent), 32'(exp_q.size()));
        end
    endtask

    initial begin
        logic [N-1:0] rlow;
        n_cmp = 0; n_err = 0;
        sel = 0; start_v = 1'b0; low_v = '0; e3_v = '0; ready_v = 1'b1;
        sys_reset = 1'b0;
        repeat (3) @(negedge sys_clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset_valid", 32'(mon_valid), 0);
            chk("reset_busy", 32'(mon_busy), 0);
            chk("reset_done", 32'(mon_done), 0);
            chk("reset_bits_sent", 32'(mon_sent), 0);
            chk("reset_bit_out", 32'(mon_bit), 0);
        end
        @(negedge sys_clk);
        sys_reset = 1'b1;
        sel = 0;
        repeat (3) begin
            @(negedge sys_clk);
            chk("idle_ready_ignored", 32'(mon_valid), 0);
        end

        run_term(0, 9'b101100110, 0, 0, 0, 0);
        run_term(0, 9'b101100110, 3, 0, 0, 0);
        run_term(0, 9'b101100110, 2, 1, 0, 0);
        run_term(0, 9'b101100110, 3, 0, 1, 0);
        run_term(0, 9'b101100110, 3, 0, 0, 4);
        run_term(0, 9'b101100110, 3, 0, 0, 0);
        run_term(1, 9'b011000000, 2, 0, 0, 0);
        run_term(2, 9'b011000000, 0, 0, 0, 0);
        run_term(0, 9'b110010101, 127, 0, 0, 0);
        run_term(2, 9'b010010101, 127, 2, 0, 0);

        for (int k = 0; k < 40; k++) begin
            rlow = N'($urandom);
            run_term($urandom_range(0, 2), rlow,
                     ($urandom_range(0, 9) == 0) ? 127 : int'($urandom_range(0, 6)),
                     $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ac_terminate_ser.md
AC_TERMINATE_SER -- requirements
Module: ac_terminate_ser

Interface
REQ-001 Parameter N, default 9: coder register word width in bits, legal range 3..16.
REQ-002 Parameter CW, default 7: width of the E3 (pending-bit) count.
REQ-003 Parameter FLUSH_BITS, default N: number of low-register bits emitted, MSB first, legal range 1..N; smaller values give a shorter termination.
REQ-004 sys_clk  in  1  clock; all state updates on the rising edge.
REQ-005 sys_reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to terminate the current codeword.
REQ-007 low_in  in  N  final low register value; sampled with start.
REQ-008 e3_in  in  CW  pending E3 count; sampled with start.
REQ-009 bit_out  out  1  serial code bit, valid while bit_valid is high.
REQ-010 bit_valid  out  1  bit_out holds a bit for transfer.
REQ-011 bit_ready  in  1  downstream accepts bit_out; a transfer occurs when bit_valid and bit_ready are both high.
REQ-012 busy  out  1  high from the cycle after start is accepted until done is asserted.
REQ-013 done  out  1  one-cycle pulse marking termination complete (terminate flag).
REQ-014 bits_sent  out  CW+5  count of bits transferred in the current termination.

Function
REQ-015 FSM states: IDLE, MSB, E3, REM, DONE; registered outputs.
REQ-016 In IDLE, start=1 latches low_in, e3_in and a zeroed bits_sent, then moves to MSB; busy rises on the next cycle.
REQ-017 While the FSM is not in IDLE, start is ignored and the latched values do not change.
REQ-018 In MSB: bit_out=low[N-1] and bit_valid=1.
  - On transfer with e3>0, go to E3.
  - Otherwise, if FLUSH_BITS>1, go to REM.
  - Otherwise, go to DONE.
REQ-019 In E3: bit_out=~low[N-1]; each transfer decrements e3. On the transfer that reaches e3=0, go to REM if FLUSH_BITS>1, else DONE.
REQ-020 In REM: bits low[N-2] down to low[N-FLUSH_BITS] are emitted, one per transfer; after the last one, go to DONE.
REQ-021 In DONE: bit_valid=0, done=1 for exactly one cycle, busy=0, then return to IDLE.
REQ-022 Backpressure: while bit_valid=1 and bit_ready=0, bit_out, state and counters hold.
REQ-023 bit_valid is never deasserted before its transfer completes.
REQ-024 Latency: the first bit_valid occurs in the cycle after start. With bit_ready held high, one bit is transferred per cycle, and done asserts the cycle after the last transfer.
REQ-025 The total number of bits per termination is exactly 1 + e3 + (FLUSH_BITS-1).
REQ-026 bits_sent increments on every transfer and holds its final value until the next accepted start.
REQ-027 e3_in equal to the maximum value 2^CW-1 is handled fully, with no wrap-around.
REQ-028 bit_valid=0 in IDLE and DONE; any bit_ready input in those states has no effect.

Reset
REQ-029 When sys_reset=0, regardless of state, the block:
  - enters IDLE;
  - drives bit_out=0, bit_valid=0, busy=0, done=0, bits_sent=0;
  - clears the latched low and e3 values.
REQ-030 Reset asserted mid-termination abandons that termination with no done pulse. After release, the block accepts a new start the first cycle it sees start=1.

Verification
REQ-031 Defaults, low_in=9'b101100110, e3_in=0, bit_ready=1 -> bits 1,0,1,1,0,0,1,1,0 on consecutive cycles; done one cycle later; bits_sent=9.
REQ-032 Same low_in, e3_in=3 -> bits 1,0,0,0,0,1,1,0,0,1,1,0; bits_sent=12; one done pulse.
REQ-033 e3_in=2, bit_ready toggling 1,0,0,1,... -> bit_out stable during stalls; sequence identical to the unstalled case; done only after the final transfer.
REQ-034 Second start pulsed while busy, with different low_in -> ignored; the original sequence completes unchanged.
REQ-035 sys_reset low after the 4th transfer of the e3=3 case -> all outputs 0 at once, no done pulse. A new start after release produces a full correct sequence.
REQ-036 FLUSH_BITS=2 instance, low_in=9'b011000000, e3_in=2 -> bits 0,1,1,1; bits_sent=4. FLUSH_BITS=1 with e3_in=0 -> single bit 0, then done.
